interrupt_sequencer: RTL and testbench
======================================

Name: interrupt_sequencer

Overview:
- Multi-cycle controller that sequences interrupt entry and return-from-interrupt (RETI) for the XM multi-cycle CPU.
- Arbitrates 8 prioritised interrupt lines against the current priority held in the program status word (PSW).
- On entry: pushes PC and PSW to the stack, loads a new PSW and fetches the handler vector. On RETI: pops both back.
- Sits beside the control unit. Owns the PSW write port, SP/PC load strobes and the memory request port while busy.

Parameters:
- VECTOR_BASE, 16'hFFC0, byte address of vector table; entry for line i at VECTOR_BASE + 2*i.
- STACK_STEP, 2, bytes per stack word.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- irq  in  8  level-sensitive interrupt lines; line i has priority i
- boundary  in  1  CPU at instruction boundary; requests accepted only when high
- reti_req  in  1  RETI decoded; sampled with boundary
- psw_in  in  16  current PSW
- sp_in  in  16  current stack pointer
- pc_in  in  16  return PC (next instruction)
- busy  out  1  sequencer active; CPU stalls, CPU must hold status_wr low
- irq_ack  out  8  one-hot one-cycle pulse when vector is loaded
- psw_wr_en  out  2  byte enables to PSW register
- psw_wr_data  out  16  PSW write data
- sp_wr  out  1  load SP from sp_out
- sp_out  out  16  new SP
- pc_wr  out  1  load PC from pc_out
- pc_out  out  16  new PC
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write
- mem_addr  out  16  word-aligned address
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data, valid with mem_ack
- mem_ack  in  1  access complete

Behaviour:
- PSW fields: [3:0] V,N,Z,C; [4] SLP; [7:5] current priority CUR; [15:13] previous priority PRV.
- Reset (async): state IDLE; every output 0; internal SP/PC/PSW snapshots cleared. Any in-flight memory access is abandoned.
- IDLE: busy = 0.
  - Sampled only when boundary = 1.
  - If reti_req: go to POP_PSW. RETI has precedence over a simultaneous irq.
  - Else, if any irq[i] with i > CUR: latch the highest such i, snapshot sp_in/pc_in/psw_in, go to PUSH_PC.
  - Line 0 can never be taken.
- busy is registered: high from the cycle after acceptance until the cycle the state returns to IDLE.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and held stable until the cycle mem_ack = 1.
  - mem_req drops the following cycle. The next access starts no earlier than one cycle later.
  - An ack arriving while mem_req = 0 is ignored.
  - No timeout; the sequencer waits indefinitely.
- Entry sequence:
  - PUSH_PC: write pc snapshot to SP-2.
  - PUSH_PSW: write psw snapshot to SP-4.
  - LOAD_VEC: read VECTOR_BASE + 2*i.
  - On the LOAD_VEC ack, in one cycle:
    - pc_wr = 1, pc_out = mem_rdata.
    - sp_wr = 1, sp_out = SP-4.
    - psw_wr_en = 2'b11; psw_wr_data has [15:13] = snapshot CUR, [12:8] = snapshot [12:8], [7:5] = i, [4:0] = 0.
    - irq_ack[i] = 1.
  - Next cycle: IDLE.
- Return sequence:
  - POP_PSW: read SP, latch the word.
  - POP_PC: read SP+2.
  - On the POP_PC ack, in one cycle: pc_wr = 1, pc_out = mem_rdata; sp_wr = 1, sp_out = SP+4; psw_wr_en = 2'b11, psw_wr_data = latched PSW verbatim.
  - Next cycle: IDLE.
- Strobes: psw_wr_en, sp_wr, pc_wr and irq_ack are single-cycle pulses, otherwise 0.
- Arithmetic: all address arithmetic is 16-bit modulo 2^16. SP = 16'h0002 pushes to 16'h0000 then 16'hFFFE, with no fault.
- irq is not re-sampled after acceptance. A line dropping mid-entry still completes entry and still pulses its ack.
- A higher irq arriving mid-sequence is considered only on return to IDLE.
- boundary and reti_req are ignored while busy.

Test Plan:
- Entry:
  - Stimulus: PSW = 16'h000F, SP = 16'h1000, PC = 16'h0200, irq = 8'h08, mem[FFC6] = 16'h4000, 1-cycle ack.
  - Required: writes [0FFE] = 0200, [0FFC] = 000F; read FFC6; PC = 4000, SP = 0FFC, PSW = 0060, irq_ack = 8'h08.
- Priority:
  - Stimulus: CUR = 3, irq = 8'b1001_0110.
  - Required: line 7 taken, new PSW [7:5] = 7, [15:13] = 3. With irq = 8'h0E instead, nothing is taken.
- RETI after the entry scenario:
  - Required: reads 0FFC then 0FFE; PSW = 000F, PC = 0200, SP = 1000; busy low 1 cycle after final ack.
- Simultaneous events:
  - Stimulus: reti_req and irq[5] (CUR = 2) in the same boundary cycle.
  - Required: return sequence runs first. irq[5] is taken at the next boundary if CUR is still below 5 after the PSW restore.
- Stall handling:
  - Stimulus: mem_ack delayed 5 cycles on each access.
  - Required: mem_addr and mem_wdata stable throughout each wait; busy stays high.
- Reset mid-op:
  - Stimulus: rst asserted during PUSH_PSW with no ack yet.
  - Required: all outputs 0 immediately (asynchronous). After release the sequencer is IDLE and re-accepts a pending irq.
- Wrap: SP = 16'h0002 on entry → pushes to 0000 and FFFE; SP = FFFE.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// Interrupt entry / RETI sequencer for the XM multi-cycle CPU.
// Pushes/pops PC and PSW over a simple req/ack memory port and drives PC/SP/PSW load strobes.
module interrupt_sequencer #(
  parameter logic [15:0] VECTOR_BASE = 16'hFFC0,
  parameter int unsigned STACK_STEP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  irq,
  input  logic        boundary,
  input  logic        reti_req,
  input  logic [15:0] psw_in,
  input  logic [15:0] sp_in,
  input  logic [15:0] pc_in,
  output logic        busy,
  output logic [7:0]  irq_ack,
  output logic [1:0]  psw_wr_en,
  output logic [15:0] psw_wr_data,
  output logic        sp_wr,
  output logic [15:0] sp_out,
  output logic        pc_wr,
  output logic [15:0] pc_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned NUM_IRQ = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned DW      = 16;

  localparam logic [DW-1:0] STEP1 = DW'(STACK_STEP);
  localparam logic [DW-1:0] STEP2 = DW'(2 * STACK_STEP);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PUSH_PC  = 3'd1;
  localparam logic [2:0] S_PUSH_PSW = 3'd2;
  localparam logic [2:0] S_LOAD_VEC = 3'd3;
  localparam logic [2:0] S_POP_PSW  = 3'd4;
  localparam logic [2:0] S_POP_PC   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DW-1:0]    sp_q, sp_d;
  logic [DW-1:0]    pc_q, pc_d;
  logic [DW-1:0]    psw_q, psw_d;

  logic               busy_d;
  logic [NUM_IRQ-1:0] irq_ack_d;
  logic [1:0]         psw_wr_en_d;
  logic [DW-1:0]      psw_wr_data_d;
  logic               sp_wr_d;
  logic [DW-1:0]      sp_out_d;
  logic               pc_wr_d;
  logic [DW-1:0]      pc_out_d;
  logic               mem_req_d;
  logic               mem_we_d;
  logic [DW-1:0]      mem_addr_d;
  logic [DW-1:0]      mem_wdata_d;

  logic             take;
  logic [IDX_W-1:0] take_idx;

  // Highest pending line strictly above the current priority; line 0 never qualifies.
  always_comb begin
    take     = 1'b0;
    take_idx = '0;
    for (int i = 1; i < NUM_IRQ; i++) begin
      if (irq[i] && (IDX_W'(i) > psw_in[7:5])) begin
        take     = 1'b1;
        take_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      sp_q        <= '0;
      pc_q        <= '0;
      psw_q       <= '0;
      busy        <= 1'b0;
      irq_ack     <= '0;
      psw_wr_en   <= '0;
      psw_wr_data <= '0;
      sp_wr       <= 1'b0;
      sp_out      <= '0;
      pc_wr       <= 1'b0;
      pc_out      <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sp_q        <= sp_d;
      pc_q        <= pc_d;
      psw_q       <= psw_d;
      busy        <= busy_d;
      irq_ack     <= irq_ack_d;
      psw_wr_en   <= psw_wr_en_d;
      psw_wr_data <= psw_wr_data_d;
      sp_wr       <= sp_wr_d;
      sp_out      <= sp_out_d;
      pc_wr       <= pc_wr_d;
      pc_out      <= pc_out_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
    end
  end

  // Each access state issues its request when mem_req is low and advances on ack,
  // which leaves at least one idle cycle between consecutive accesses.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    sp_d          = sp_q;
    pc_d          = pc_q;
    psw_d         = psw_q;
    busy_d        = busy;
    irq_ack_d     = '0;
    psw_wr_en_d   = '0;
    psw_wr_data_d = '0;
    sp_wr_d       = 1'b0;
    sp_out_d      = '0;
    pc_wr_d       = 1'b0;
    pc_out_d      = '0;
    mem_req_d     = mem_req;
    mem_we_d      = mem_we;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (boundary) begin
          if (reti_req) begin
            state_d = S_POP_PSW;
            sp_d    = sp_in;
            busy_d  = 1'b1;
          end else if (take) begin
            state_d = S_PUSH_PC;
            idx_d   = take_idx;
            sp_d    = sp_in;
            pc_d    = pc_in;
            psw_d   = psw_in;
            busy_d  = 1'b1;
          end
        end
      end

      S_PUSH_PC: begin
        if (!mem_req) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = sp_q - STEP1;
          mem_wdata_d = pc_q;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_PUSH_PSW;
        end
      end

      S_PUSH_PSW: begin
        if (!mem_req) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = sp_q - STEP2;
          mem_wdata_d = psw_q;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_LOAD_VEC;
        end
      end

      S_LOAD_VEC: begin
        if (!mem_req) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = VECTOR_BASE + DW'({idx_q, 1'b0});
          mem_wdata_d = '0;
        end else if (mem_ack) begin
          mem_req_d     = 1'b0;
          state_d       = S_IDLE;
          busy_d        = 1'b0;
          pc_wr_d       = 1'b1;
          pc_out_d      = mem_rdata;
          sp_wr_d       = 1'b1;
          sp_out_d      = sp_q - STEP2;
          psw_wr_en_d   = 2'b11;
          psw_wr_data_d = {psw_q[7:5], psw_q[12:8], idx_q, 5'b0};
          irq_ack_d     = NUM_IRQ'(1) << idx_q;
        end
      end

      S_POP_PSW: begin
        if (!mem_req) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = sp_q;
          mem_wdata_d = '0;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          psw_d     = mem_rdata;
          state_d   = S_POP_PC;
        end
      end

      S_POP_PC: begin
        if (!mem_req) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = sp_q + STEP1;
          mem_wdata_d = '0;
        end else if (mem_ack) begin
          mem_req_d     = 1'b0;
          state_d       = S_IDLE;
          busy_d        = 1'b0;
          pc_wr_d       = 1'b1;
          pc_out_d      = mem_rdata;
          sp_wr_d       = 1'b1;
          sp_out_d      = sp_q + STEP2;
          psw_wr_en_d   = 2'b11;
          psw_wr_data_d = psw_q;
        end
      end

      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: directed scenarios push expected memory
// accesses and completion strobes; a monitor pops and compares them as the DUT presents them.
module tb_interrupt_sequencer;

  logic        clk;
  logic        rst;
  logic [7:0]  irq;
  logic        boundary;
  logic        reti_req;
  logic [15:0] psw_in;
  logic [15:0] sp_in;
  logic [15:0] pc_in;
  logic        busy;
  logic [7:0]  irq_ack;
  logic [1:0]  psw_wr_en;
  logic [15:0] psw_wr_data;
  logic        sp_wr;
  logic [15:0] sp_out;
  logic        pc_wr;
  logic [15:0] pc_out;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  interrupt_sequencer dut (
    .clk(clk), .rst(rst), .irq(irq), .boundary(boundary), .reti_req(reti_req),
    .psw_in(psw_in), .sp_in(sp_in), .pc_in(pc_in), .busy(busy), .irq_ack(irq_ack),
    .psw_wr_en(psw_wr_en), .psw_wr_data(psw_wr_data), .sp_wr(sp_wr), .sp_out(sp_out),
    .pc_wr(pc_wr), .pc_out(pc_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] sp;
    logic [15:0] psw;
    logic [7:0]  ack;
  } fin_t;

  acc_t exp_acc[$];
  fin_t exp_fin[$];
  logic [15:0] mem [logic [15:0]];
  int ack_delay;
  int n_cmp;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_w(input logic [15:0] a, input logic [15:0] d);
    exp_acc.push_back('{we: 1'b1, addr: a, wdata: d});
  endtask

  task automatic push_r(input logic [15:0] a);
    exp_acc.push_back('{we: 1'b0, addr: a, wdata: 16'h0});
  endtask

  task automatic push_fin(input logic [15:0] p, input logic [15:0] s, input logic [15:0] w,
                          input logic [7:0] k);
    exp_fin.push_back('{pc: p, sp: s, psw: w, ack: k});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_irq_ack"}, 32'(irq_ack), 32'h0);
    check({tag, "_psw_wr"}, {14'h0, psw_wr_en, psw_wr_data}, 32'h0);
    check({tag, "_sp"}, {15'h0, sp_wr, sp_out}, 32'h0);
    check({tag, "_pc"}, {15'h0, pc_wr, pc_out}, 32'h0);
    check({tag, "_mem_ctl"}, {30'h0, mem_req, mem_we}, 32'h0);
    check({tag, "_mem_bus"}, {mem_addr, mem_wdata}, 32'h0);
  endtask

  task automatic issue(input logic [15:0] p, input logic [15:0] s, input logic [15:0] c,
                       input logic [7:0] iv, input logic rr, input logic exp_busy);
    @(negedge clk);
    psw_in   = p;
    sp_in    = s;
    pc_in    = c;
    irq      = iv;
    reti_req = rr;
    boundary = 1'b1;
    @(negedge clk);
    boundary = 1'b0;
    reti_req = 1'b0;
    #1 check("busy_after_boundary", 32'(busy), 32'(exp_busy));
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((busy || exp_acc.size() != 0 || exp_fin.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got busy=%0b pending=%0d expected idle with nothing pending",
               name, busy, exp_acc.size() + exp_fin.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Memory responder: acks after ack_delay cycles, checks the request stays stable meanwhile.
  initial begin
    acc_t seen;
    logic aborted;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (!rst && mem_req) begin
        seen    = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
        aborted = 1'b0;
        for (int k = 0; k < ack_delay; k++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          check("stall_req_held", 32'(mem_req), 32'h1);
          check("stall_addr_stable", 32'(mem_addr), 32'(seen.addr));
          check("stall_wdata_stable", {15'h0, mem_we, mem_wdata}, {15'h0, seen.we, seen.wdata});
          check("stall_busy", 32'(busy), 32'h1);
        end
        if (!aborted) begin
          mem_rdata = seen.we ? 16'h0 : (mem.exists(seen.addr) ? mem[seen.addr] : 16'h0);
          if (seen.we) mem[seen.addr] = seen.wdata;
          mem_ack = 1'b1;
          @(negedge clk);
          mem_ack   = 1'b0;
          mem_rdata = 16'h0;
        end
      end
    end
  end

  // Monitor: pops expected accesses at each ack and expected results at each strobe cycle.
  initial begin
    acc_t ea;
    fin_t ef;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && mem_req && mem_ack) begin
        if (exp_acc.size() == 0) begin
          check("unexpected_access_addr", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          ea = exp_acc.pop_front();
          check("acc_we", 32'(mem_we), 32'(ea.we));
          check("acc_addr", 32'(mem_addr), 32'(ea.addr));
          if (ea.we) check("acc_wdata", 32'(mem_wdata), 32'(ea.wdata));
        end
      end
      if (!rst && (pc_wr || sp_wr || psw_wr_en != 2'b00 || irq_ack != 8'h00)) begin
        if (exp_fin.size() == 0) begin
          check("unexpected_strobe_pc", 32'(pc_out), 32'hFFFF_FFFF);
        end else begin
          ef = exp_fin.pop_front();
          check("fin_strobes", {28'h0, pc_wr, sp_wr, psw_wr_en}, 32'hF);
          check("fin_pc", 32'(pc_out), 32'(ef.pc));
          check("fin_sp", 32'(sp_out), 32'(ef.sp));
          check("fin_psw", 32'(psw_wr_data), 32'(ef.psw));
          check("fin_irq_ack", 32'(irq_ack), 32'(ef.ack));
          check("fin_busy_low", 32'(busy), 32'h0);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected $finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_cmp     = 0;
    n_err     = 0;
    ack_delay = 0;
    rst       = 1'b1;
    irq       = 8'h00;
    boundary  = 1'b0;
    reti_req  = 1'b0;
    psw_in    = 16'h0;
    sp_in     = 16'h0;
    pc_in     = 16'h0;
    mem[16'hFFC2] = 16'h1111;
    mem[16'hFFC4] = 16'h7777;
    mem[16'hFFC6] = 16'h4000;
    mem[16'hFFC8] = 16'h2222;
    mem[16'hFFCA] = 16'h6000;
    mem[16'hFFCE] = 16'h5000;
    mem[16'h3000] = 16'h0085;
    mem[16'h3002] = 16'h0500;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Entry: line 3 over CUR=0
    push_w(16'h0FFE, 16'h0200);
    push_w(16'h0FFC, 16'h000F);
    push_r(16'hFFC6);
    push_fin(16'h4000, 16'h0FFC, 16'h0060, 8'h08);
    issue(16'h000F, 16'h1000, 16'h0200, 8'h08, 1'b0, 1'b1);
    irq = 8'h00;
    wait_done("entry");

    // RETI back from that entry
    push_r(16'h0FFC);
    push_r(16'h0FFE);
    push_fin(16'h0200, 16'h1000, 16'h000F, 8'h00);
    issue(16'h0060, 16'h0FFC, 16'h4000, 8'h00, 1'b1, 1'b1);
    wait_done("reti");

    // No line above CUR=3: nothing taken
    issue(16'h0060, 16'h2000, 16'h0300, 8'h0E, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #1 check("no_take_busy", 32'(busy), 32'h0);
    irq = 8'h00;

    // Priority: lines 1,2,4,7 pending with CUR=3 -> line 7
    push_w(16'h1FFE, 16'h0300);
    push_w(16'h1FFC, 16'h0060);
    push_r(16'hFFCE);
    push_fin(16'h5000, 16'h1FFC, 16'h60E0, 8'h80);
    issue(16'h0060, 16'h2000, 16'h0300, 8'h96, 1'b0, 1'b1);
    irq = 8'h00;
    wait_done("priority");

    // RETI and irq[5] together: RETI first, then irq[5] at the next boundary
    push_r(16'h3000);
    push_r(16'h3002);
    push_fin(16'h0500, 16'h3004, 16'h0085, 8'h00);
    issue(16'h0040, 16'h3000, 16'h0777, 8'h20, 1'b1, 1'b1);
    wait_done("simul_reti");
    push_w(16'h3002, 16'h0500);
    push_w(16'h3000, 16'h0085);
    push_r(16'hFFCA);
    push_fin(16'h6000, 16'h3000, 16'h80A0, 8'h20);
    issue(16'h0085, 16'h3004, 16'h0500, 8'h20, 1'b0, 1'b1);
    irq = 8'h00;
    wait_done("simul_irq");

    // Stalled memory: 5-cycle ack on entry and return
    ack_delay = 5;
    push_w(16'h3FFE, 16'h0123);
    push_w(16'h3FFC, 16'h0A25);
    push_r(16'hFFC4);
    push_fin(16'h7777, 16'h3FFC, 16'h2A40, 8'h04);
    issue(16'h0A25, 16'h4000, 16'h0123, 8'h04, 1'b0, 1'b1);
    irq = 8'h00;
    wait_done("stall_entry");
    push_r(16'h3FFC);
    push_r(16'h3FFE);
    push_fin(16'h0123, 16'h4000, 16'h0A25, 8'h00);
    issue(16'h2A40, 16'h3FFC, 16'h7777, 8'h00, 1'b1, 1'b1);
    wait_done("stall_reti");

    // Reset while the PSW push waits for its ack
    push_w(16'h4FFE, 16'h0010);
    push_w(16'h4FFC, 16'h0000);
    push_r(16'hFFC2);
    push_fin(16'h1111, 16'h4FFC, 16'h0020, 8'h02);
    issue(16'h0000, 16'h5000, 16'h0010, 8'h02, 1'b0, 1'b1);
    n = 0;
    while (!(mem_req && mem_addr == 16'h4FFC) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_push_psw_addr", 32'(mem_addr), 32'h4FFC);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_acc.delete();
    exp_fin.delete();
    ack_delay = 0;
    @(negedge clk);
    #1 check("post_reset_idle", 32'(busy), 32'h0);
    push_w(16'h4FFE, 16'h0010);
    push_w(16'h4FFC, 16'h0000);
    push_r(16'hFFC2);
    push_fin(16'h1111, 16'h4FFC, 16'h0020, 8'h02);
    issue(16'h0000, 16'h5000, 16'h0010, 8'h02, 1'b0, 1'b1);
    irq = 8'h00;
    wait_done("reaccept");

    // Stack pointer wrap below zero
    push_w(16'h0000, 16'hABCD);
    push_w(16'hFFFE, 16'h0000);
    push_r(16'hFFC8);
    push_fin(16'h2222, 16'hFFFE, 16'h0080, 8'h10);
    issue(16'h0000, 16'h0002, 16'hABCD, 8'h10, 1'b0, 1'b1);
    irq = 8'h00;
    wait_done("wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
